// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared arbitration types and round-robin search helper
package fifo_pkg;

    // Arbiter FSM encoding: idle/arbitrating vs. holding a packet grant
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Widest requester set the round-robin helper supports
    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = 4;

    // First set bit of mask strictly after last_idx, searching circularly
    // over the lowest num bits; returns last_idx when nothing else is set
    // (and last_idx itself if it is the only set bit).
    function automatic logic [RR_IDX_W-1:0] rr_next(
        input logic [RR_MAX-1:0]   mask,
        input logic [RR_IDX_W-1:0] last_idx,
        input int unsigned         num
    );
        logic [RR_IDX_W-1:0] pick;
        logic                found;
        logic [RR_MAX-1:0]   shifted;
        int unsigned         idx;
        pick  = last_idx;
        found = 1'b0;
        for (int unsigned off = 1; off <= RR_MAX; off++) begin
            idx     = (32'(last_idx) + off) % num;
            shifted = mask >> idx;
            if (!found && off <= num && shifted[0]) begin
                pick  = RR_IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port bundle for the arbiter
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          wr_en;
    logic [DATA_WIDTH:0]           wr_data;

    // Arbiter side: consumes requester beats, drives the FIFO write port
    modport master (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, wr_en, wr_data
    );

    // Environment side: requesters plus the FIFO write controller
    modport slave (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, wr_en, wr_data
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational circular priority picker
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0]   last_idx_i,
    output logic [IDX_W-1:0]   pick_idx_o,
    output logic               pick_valid_o
);

    logic [RR_MAX-1:0]   mask_ext;
    logic [RR_IDX_W-1:0] last_ext;
    logic [RR_IDX_W-1:0] pick_ext;

    // Widen to the helper's fixed width and search after the last winner
    always_comb begin
        mask_ext = RR_MAX'(mask_i);
        last_ext = RR_IDX_W'(last_idx_i);
        pick_ext = rr_next(mask_ext, last_ext, NUM_REQ);
    end

    assign pick_idx_o   = IDX_W'(pick_ext);
    assign pick_valid_o = |mask_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - packet-locked round-robin arbiter for the async FIFO write port
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BEATS  = 16,
    localparam int IDX_W      = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(MAX_BEATS + 1)
) (
    input  logic               wr_clk,
    input  logic               wr_rst_n,
    fifo_wr_arbiter_if.master  bus,
    output logic [IDX_W-1:0]   grant_id,
    output logic               busy,
    output logic               err_overlen
);

    arb_state_e       state_q;
    logic [IDX_W-1:0] grant_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             err_q;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             holding;
    logic             accept;
    logic             beat_last;
    logic             cap_hit;
    logic             pkt_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .mask_i       (bus.req_valid),
        .last_idx_i   (grant_q),
        .pick_idx_o   (pick_idx),
        .pick_valid_o (pick_valid)
    );

    // Beat acceptance and packet-termination decode for the granted requester
    always_comb begin
        holding   = (state_q == ST_BUSY);
        accept    = holding & bus.req_valid[grant_q] & ~bus.fifo_full;
        beat_last = bus.req_last[grant_q];
        cap_hit   = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
        pkt_end   = accept & (beat_last | cap_hit);
    end

    // Only the granted requester may see ready, and only while the FIFO has room
    always_comb begin
        bus.req_ready = '0;
        if (holding) begin
            bus.req_ready[grant_q] = ~bus.fifo_full;
        end
    end

    // Write port mux; an over-length packet gets its last bit forced on the capped beat
    always_comb begin
        bus.wr_en   = accept;
        bus.wr_data = {beat_last | cap_hit,
                       bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH]};
    end

    // FSM: arbitrate in IDLE, hold the grant until last or the beat cap in BUSY
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= IDX_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (pkt_end) begin
                        state_q    <= ST_IDLE;
                        beat_cnt_q <= '0;
                        if (!beat_last) begin
                            err_q <= 1'b1;
                        end
                    end else if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_id    = grant_q;
    assign busy        = holding;
    assign err_overlen = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_overlen;
    int         chk_cnt  = 0;
    int         pass_cnt = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .wr_clk      (clk),
        .wr_rst_n    (rst_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_overlen (err_overlen)
    );

    always #5 clk = ~clk;

    // Observed status word: {err, busy, wr_en, req_ready[3:0], grant_id}
    function automatic logic [8:0] status();
        return {err_overlen, busy, bus.wr_en, bus.req_ready, grant_id};
    endfunction

    function automatic logic [8:0] st(input logic e, input logic b, input logic w,
                                      input logic [3:0] rdy, input logic [1:0] g);
        return {e, b, w, rdy, g};
    endfunction

    task automatic drive(input int r, input logic v, input logic l, input logic [7:0] d);
        bus.req_valid[r]          = v;
        bus.req_last[r]           = l;
        bus.req_data[r*DW +: DW]  = d;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        @(negedge clk); #1;
        e = st(1'b0, 1'b0, 1'b0, 4'b0000, 2'd3);
        chk_cnt++;
        if (status() !== e) $display("FAIL reset_status act=%h exp=%h", status(), e); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_packet();
        logic [8:0] e;
        logic [7:0] d;
        @(negedge clk); drive(0, 1'b1, 1'b0, 8'h11); #1;
        e = st(1'b0, 1'b0, 1'b0, 4'b0000, 2'd3);
        chk_cnt++;
        if (status() !== e) $display("FAIL pkt_idle act=%h exp=%h", status(), e); else pass_cnt++;
        for (int b = 0; b < 3; b++) begin
            d = 8'(17 * (b + 1));
            @(negedge clk); drive(0, 1'b1, (b == 2), d); #1;
            e = st(1'b0, 1'b1, 1'b1, 4'b0001, 2'd0);
            chk_cnt++;
            if (status() !== e) $display("FAIL pkt_beat%0d_status act=%h exp=%h", b, status(), e); else pass_cnt++;
            chk_cnt++;
            if (bus.wr_data !== {(b == 2), d}) $display("FAIL pkt_beat%0d_data act=%h exp=%h", b, bus.wr_data, {(b == 2), d}); else pass_cnt++;
        end
        @(negedge clk); drive(0, 1'b0, 1'b0, 8'h00); #1;
        e = st(1'b0, 1'b0, 1'b0, 4'b0000, 2'd0);
        chk_cnt++;
        if (status() !== e) $display("FAIL pkt_busy_fall act=%h exp=%h", status(), e); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [8:0] e;
        logic [1:0] g;
        test_reset();
        @(negedge clk);
        for (int r = 0; r < NR; r++) drive(r, 1'b1, 1'b1, 8'(8'h40 + r));
        #1;
        e = st(1'b0, 1'b0, 1'b0, 4'b0000, 2'd3);
        chk_cnt++;
        if (status() !== e) $display("FAIL rr_idle act=%h exp=%h", status(), e); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            g = 2'(k % NR);
            @(negedge clk); #1;
            e = st(1'b0, 1'b1, 1'b1, 4'(1 << g), g);
            chk_cnt++;
            if (status() !== e) $display("FAIL rr_grant%0d act=%h exp=%h", k, status(), e); else pass_cnt++;
            chk_cnt++;
            if (bus.wr_data !== {1'b1, 8'(8'h40 + g)}) $display("FAIL rr_data%0d act=%h exp=%h", k, bus.wr_data, {1'b1, 8'(8'h40 + g)}); else pass_cnt++;
            @(negedge clk);
            if (k == 4) bus.req_valid = '0;
            #1;
            e = st(1'b0, 1'b0, 1'b0, 4'b0000, g);
            chk_cnt++;
            if (status() !== e) $display("FAIL rr_bubble%0d act=%h exp=%h", k, status(), e); else pass_cnt++;
        end
    endtask

    task automatic test_fifo_full();
        logic [8:0] e;
        @(negedge clk); drive(1, 1'b1, 1'b0, 8'h51); #1;
        e = st(1'b0, 1'b0, 1'b0, 4'b0000, 2'd0);
        chk_cnt++;
        if (status() !== e) $display("FAIL full_idle act=%h exp=%h", status(), e); else pass_cnt++;
        @(negedge clk); #1;
        e = st(1'b0, 1'b1, 1'b1, 4'b0010, 2'd1);
        chk_cnt++;
        if (status() !== e || bus.wr_data !== 9'h051) $display("FAIL full_beat1 act=%h/%h exp=%h/051", status(), bus.wr_data, e); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(1, 1'b1, 1'b0, 8'h52); bus.fifo_full = 1'b1; #1;
            e = st(1'b0, 1'b1, 1'b0, 4'b0000, 2'd1);
            chk_cnt++;
            if (status() !== e) $display("FAIL full_stall%0d act=%h exp=%h", i, status(), e); else pass_cnt++;
        end
        for (int b = 2; b <= 4; b++) begin
            @(negedge clk); bus.fifo_full = 1'b0; drive(1, 1'b1, (b == 4), 8'(8'h50 + b)); #1;
            e = st(1'b0, 1'b1, 1'b1, 4'b0010, 2'd1);
            chk_cnt++;
            if (status() !== e) $display("FAIL full_resume%0d_status act=%h exp=%h", b, status(), e); else pass_cnt++;
            chk_cnt++;
            if (bus.wr_data !== {(b == 4), 8'(8'h50 + b)}) $display("FAIL full_resume%0d_data act=%h exp=%h", b, bus.wr_data, {(b == 4), 8'(8'h50 + b)}); else pass_cnt++;
        end
        @(negedge clk); drive(1, 1'b0, 1'b0, 8'h00); #1;
        e = st(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1);
        chk_cnt++;
        if (status() !== e) $display("FAIL full_done act=%h exp=%h", status(), e); else pass_cnt++;
    endtask

    task automatic test_overlen();
        logic [8:0] e;
        @(negedge clk); drive(2, 1'b1, 1'b0, 8'h61); #1;
        e = st(1'b0, 1'b0, 1'b0, 4'b0000, 2'd1);
        chk_cnt++;
        if (status() !== e) $display("FAIL ovl_idle act=%h exp=%h", status(), e); else pass_cnt++;
        for (int k = 1; k <= MB; k++) begin
            @(negedge clk); drive(2, 1'b1, 1'b0, 8'(8'h60 + k)); #1;
            e = st(1'b0, 1'b1, 1'b1, 4'b0100, 2'd2);
            chk_cnt++;
            if (status() !== e) $display("FAIL ovl_beat%0d_status act=%h exp=%h", k, status(), e); else pass_cnt++;
            chk_cnt++;
            if (bus.wr_data !== {(k == MB), 8'(8'h60 + k)}) $display("FAIL ovl_beat%0d_data act=%h exp=%h", k, bus.wr_data, {(k == MB), 8'(8'h60 + k)}); else pass_cnt++;
        end
        @(negedge clk); drive(2, 1'b1, 1'b0, 8'h71); #1;
        e = st(1'b1, 1'b0, 1'b0, 4'b0000, 2'd2);
        chk_cnt++;
        if (status() !== e) $display("FAIL ovl_release act=%h exp=%h", status(), e); else pass_cnt++;
        for (int k = 17; k <= 20; k++) begin
            @(negedge clk); drive(2, 1'b1, (k == 20), 8'(8'h60 + k)); #1;
            e = st(1'b1, 1'b1, 1'b1, 4'b0100, 2'd2);
            chk_cnt++;
            if (status() !== e || bus.wr_data !== {(k == 20), 8'(8'h60 + k)})
                $display("FAIL ovl_tail%0d act=%h/%h exp=%h/%h", k, status(), bus.wr_data, e, {(k == 20), 8'(8'h60 + k)});
            else pass_cnt++;
        end
        @(negedge clk); drive(2, 1'b0, 1'b0, 8'h00); #1;
        e = st(1'b1, 1'b0, 1'b0, 4'b0000, 2'd2);
        chk_cnt++;
        if (status() !== e) $display("FAIL ovl_sticky act=%h exp=%h", status(), e); else pass_cnt++;
    endtask

    task automatic test_valid_drop();
        logic [8:0] e;
        @(negedge clk); drive(3, 1'b1, 1'b0, 8'hA1); #1;
        e = st(1'b1, 1'b0, 1'b0, 4'b0000, 2'd2);
        chk_cnt++;
        if (status() !== e) $display("FAIL drop_idle act=%h exp=%h", status(), e); else pass_cnt++;
        @(negedge clk); #1;
        e = st(1'b1, 1'b1, 1'b1, 4'b1000, 2'd3);
        chk_cnt++;
        if (status() !== e || bus.wr_data !== 9'h0A1) $display("FAIL drop_beat1 act=%h/%h exp=%h/0a1", status(), bus.wr_data, e); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(3, 1'b0, 1'b0, 8'h00); drive(1, 1'b1, 1'b1, 8'h99); #1;
            e = st(1'b1, 1'b1, 1'b0, 4'b1000, 2'd3);
            chk_cnt++;
            if (status() !== e) $display("FAIL drop_hold%0d act=%h exp=%h", i, status(), e); else pass_cnt++;
        end
        for (int b = 2; b <= 3; b++) begin
            @(negedge clk); drive(3, 1'b1, (b == 3), 8'(8'hA0 + b)); #1;
            e = st(1'b1, 1'b1, 1'b1, 4'b1000, 2'd3);
            chk_cnt++;
            if (status() !== e || bus.wr_data !== {(b == 3), 8'(8'hA0 + b)})
                $display("FAIL drop_beat%0d act=%h/%h exp=%h/%h", b, status(), bus.wr_data, e, {(b == 3), 8'(8'hA0 + b)});
            else pass_cnt++;
        end
        @(negedge clk); drive(3, 1'b0, 1'b0, 8'h00); #1;
        e = st(1'b1, 1'b0, 1'b0, 4'b0000, 2'd3);
        chk_cnt++;
        if (status() !== e) $display("FAIL drop_idle2 act=%h exp=%h", status(), e); else pass_cnt++;
        @(negedge clk); #1;
        e = st(1'b1, 1'b1, 1'b1, 4'b0010, 2'd1);
        chk_cnt++;
        if (status() !== e || bus.wr_data !== 9'h199) $display("FAIL drop_next act=%h/%h exp=%h/199", status(), bus.wr_data, e); else pass_cnt++;
        @(negedge clk); drive(1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_async_reset();
        logic [8:0] e;
        @(negedge clk); drive(2, 1'b1, 1'b0, 8'hC1); #1;
        e = st(1'b1, 1'b0, 1'b0, 4'b0000, 2'd1);
        chk_cnt++;
        if (status() !== e) $display("FAIL arst_idle act=%h exp=%h", status(), e); else pass_cnt++;
        @(negedge clk); #1;
        e = st(1'b1, 1'b1, 1'b1, 4'b0100, 2'd2);
        chk_cnt++;
        if (status() !== e) $display("FAIL arst_beat1 act=%h exp=%h", status(), e); else pass_cnt++;
        @(negedge clk); drive(2, 1'b1, 1'b0, 8'hC2); #2;
        rst_n = 1'b0; #1;
        e = st(1'b0, 1'b0, 1'b0, 4'b0000, 2'd3);
        chk_cnt++;
        if (status() !== e) $display("FAIL arst_immediate act=%h exp=%h", status(), e); else pass_cnt++;
        for (int r = 0; r < NR; r++) drive(r, 1'b1, 1'b1, 8'(8'hD0 + r));
        @(negedge clk); rst_n = 1'b1; #1;
        e = st(1'b0, 1'b0, 1'b0, 4'b0000, 2'd3);
        chk_cnt++;
        if (status() !== e) $display("FAIL arst_release act=%h exp=%h", status(), e); else pass_cnt++;
        @(negedge clk); #1;
        e = st(1'b0, 1'b1, 1'b1, 4'b0001, 2'd0);
        chk_cnt++;
        if (status() !== e || bus.wr_data !== 9'h1D0) $display("FAIL arst_first_grant act=%h/%h exp=%h/1d0", status(), bus.wr_data, e); else pass_cnt++;
        @(negedge clk); bus.req_valid = '0;
    endtask

    task automatic test_random();
        logic [8:0] q [NR][$];
        logic [3:0] pres;
        logic       m_busy;
        logic [1:0] m_grant;
        int         m_beats;
        logic       m_err;
        logic [8:0] e;
        logic [8:0] head;
        logic [3:0] e_rdy;
        logic       e_wr;
        logic       e_last;
        int         len;
        int         c;
        logic       found;
        test_reset();
        pres    = '0;
        m_busy  = 1'b0;
        m_grant = 2'd3;
        m_beats = 0;
        m_err   = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                if (q[r].size() == 0) begin
                    len = $urandom_range(1, 20);
                    for (int i = 0; i < len; i++) q[r].push_back({(i == len - 1), 8'($urandom)});
                end
                if (!pres[r] && $urandom_range(0, 9) < 7) pres[r] = 1'b1;
                head = q[r][0];
                drive(r, pres[r], head[8], head[7:0]);
            end
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            e_rdy  = '0;
            e_wr   = 1'b0;
            e_last = 1'b0;
            head   = q[m_grant][0];
            if (m_busy) begin
                e_rdy  = bus.fifo_full ? 4'b0000 : 4'(1 << m_grant);
                e_wr   = pres[m_grant] && !bus.fifo_full;
                e_last = head[8] || (m_beats + 1 == MB);
            end
            #1;
            e = st(m_err, m_busy, e_wr, e_rdy, m_grant);
            chk_cnt++;
            if (status() !== e) $display("FAIL rand_status cyc=%0d act=%h exp=%h", cyc, status(), e); else pass_cnt++;
            if (e_wr) begin
                chk_cnt++;
                if (bus.wr_data !== {e_last, head[7:0]}) $display("FAIL rand_data cyc=%0d act=%h exp=%h", cyc, bus.wr_data, {e_last, head[7:0]}); else pass_cnt++;
            end
            if (!m_busy) begin
                found = 1'b0;
                for (int off = 1; off <= NR; off++) begin
                    c = (int'(m_grant) + off) % NR;
                    if (!found && pres[c]) begin
                        found   = 1'b1;
                        m_grant = 2'(c);
                    end
                end
                if (found) m_busy = 1'b1;
            end else if (e_wr) begin
                void'(q[m_grant].pop_front());
                pres[m_grant] = 1'b0;
                m_beats++;
                if (e_last) begin
                    if (!head[8]) m_err = 1'b1;
                    m_busy  = 1'b0;
                    m_beats = 0;
                end
            end
        end
        @(negedge clk);
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_fifo_full();
        test_overlen();
        test_valid_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
